// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed sequencer.
package systolic_pkg;

  localparam int N          = 4;
  localparam int FEED_BEATS = 2 * N - 1;
  localparam int BEAT_W     = $clog2(FEED_BEATS);
  localparam int DRAIN_W    = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Host-side write/start port and array-side feed outputs of the sequencer.
interface systolic_feed_ctrl_if #(
  parameter int DATASIZE = 2
);
  import systolic_pkg::*;

  logic                         wr_en;
  logic                         wr_sel;
  logic [1:0]                   wr_row;
  logic [1:0]                   wr_col;
  logic signed [DATASIZE-1:0]   wr_data;
  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         pe_reset;
  logic [N*DATASIZE-1:0]        a_out;
  logic [N*DATASIZE-1:0]        b_out;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, pe_reset, a_out, b_out
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, pe_reset, a_out, b_out
  );

endinterface

// File: rtl/systolic_feed_ctrl_skew_mux.sv
// Selects the diagonally skewed feed values for one beat from a 4x4 matrix.
// Row mode: slice i = M[i][t-i]. Column mode: slice j = M[t-j][j].
module skew_mux
  import systolic_pkg::*;
#(
  parameter int DATASIZE  = 2,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic signed [DATASIZE-1:0] mat_i [N][N],
  input  logic [BEAT_W-1:0]          beat_i,
  output logic [N*DATASIZE-1:0]      feed_o
);

  // Slice s carries element k of its row/column when t == s + k, zero otherwise.
  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    feed_o = '0;
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(beat_i) == s + k) begin
          feed_o[s*DATASIZE +: DATASIZE] = COL_MAJOR ? mat_i[k][s] : mat_i[s][k];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the 4x4 systolic PE array: stores A/B operands, then on start
// clears the array, feeds seven skewed beats, waits for drain and pulses done.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DATASIZE     = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  systolic_feed_ctrl_if.slave bus
);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FEED_BEATS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [DRAIN_W-1:0]          drain_q, drain_d;

  logic signed [DATASIZE-1:0]  mat_a_q [N][N];
  logic signed [DATASIZE-1:0]  mat_b_q [N][N];

  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        pe_reset_q, pe_reset_d;
  logic [N*DATASIZE-1:0]       a_out_q, a_out_d;
  logic [N*DATASIZE-1:0]       b_out_q, b_out_d;
  logic [N*DATASIZE-1:0]       a_feed, b_feed;
  logic                        wr_ok;

  // Writes are only taken while no run is in flight.
  assign wr_ok = bus.wr_en && !busy_q;

  // State register with beat and drain counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        beat_d  = '0;
        drain_d = '0;
        if (bus.start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_FEED;
        beat_d  = '0;
      end
      ST_FEED: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = ST_DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  skew_mux #(.DATASIZE(DATASIZE), .COL_MAJOR(1'b0)) u_skew_a (
    .mat_i  (mat_a_q),
    .beat_i (beat_d),
    .feed_o (a_feed)
  );

  skew_mux #(.DATASIZE(DATASIZE), .COL_MAJOR(1'b1)) u_skew_b (
    .mat_i  (mat_b_q),
    .beat_i (beat_d),
    .feed_o (b_feed)
  );

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    pe_reset_d = (state_d == ST_CLEAR);
    a_out_d    = (state_d == ST_FEED) ? a_feed : '0;
    b_out_d    = (state_d == ST_FEED) ? b_feed : '0;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pe_reset_q <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      pe_reset_q <= pe_reset_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
    end
  end

  // Operand storage; persists across runs, cleared only by reset.
  // NOTE: the operand arrays are reset explicitly because a run after reset must feed zeros, not stale values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_a_q[r][c] <= '0;
          mat_b_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (bus.wr_sel == SEL_A)      mat_a_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else if (bus.wr_sel == SEL_B) mat_b_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pe_reset = pe_reset_q;
  assign bus.a_out    = a_out_q;
  assign bus.b_out    = b_out_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: stimulus pushes expected runs,
// a monitor follows each run from pe_reset through done and compares.
module tb_systolic_feed_ctrl;
  import systolic_pkg::*;

  localparam int DS    = 2;
  localparam int DRAIN = 4;
  localparam int FW    = N * DS;

  typedef struct {
    logic [FW-1:0] a [FEED_BEATS];
    logic [FW-1:0] b [FEED_BEATS];
    int            clr;
  } run_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.DATASIZE(DS)) bus_if ();

  systolic_feed_ctrl #(.DATASIZE(DS), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_if)
  );

  run_t                 exp_q [$];
  int                   n_tests     = 0;
  int                   n_fail      = 0;
  int                   cyc         = 0;
  int                   runs_seen   = 0;
  int                   runs_issued = 0;
  bit                   mon_en      = 1'b0;
  logic signed [DS-1:0] m_a [N][N];
  logic signed [DS-1:0] m_b [N][N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference feed for one beat straight from the skew formula.
  function automatic logic [FW-1:0] model_feed(input logic signed [DS-1:0] m [N][N],
                                               input int t, input bit col);
    logic [FW-1:0] f;
    int            k;
    f = '0;
    for (int s = 0; s < N; s++) begin
      k = t - s;
      if (k >= 0 && k < N) f[s*DS +: DS] = col ? m[k][s] : m[s][k];
    end
    return f;
  endfunction

  function automatic run_t model_run(input int clr);
    run_t r;
    r.clr = clr;
    for (int t = 0; t < FEED_BEATS; t++) begin
      r.a[t] = model_feed(m_a, t, 1'b0);
      r.b[t] = model_feed(m_b, t, 1'b1);
    end
    return r;
  endfunction

  task automatic wr(input logic sel, input int r, input int c, input int v, input bit upd);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = sel;
    bus_if.wr_row  = 2'(r);
    bus_if.wr_col  = 2'(c);
    bus_if.wr_data = DS'(v);
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    if (upd) begin
      if (sel == SEL_B) m_b[r][c] = DS'(v);
      else              m_a[r][c] = DS'(v);
    end
  endtask

  task automatic start_with(input run_t r);
    exp_q.push_back(r);
    runs_issued++;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic start_run();
    start_with(model_run(cyc + 1));
  endtask

  task automatic wait_runs();
    int w;
    w = 0;
    while (runs_seen < runs_issued && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("runs_complete", runs_seen, runs_issued);
    @(negedge clk);
  endtask

  // Monitor: follows every run the DUT starts and checks it against the queue.
  initial begin
    run_t cur;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_if.pe_reset === 1'b1) begin
          check("run_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("clear_cycle", cyc, cur.clr);
            check("clear_busy", bus_if.busy, 1);
            check("clear_feed_zero", {bus_if.a_out, bus_if.b_out}, 0);
            for (int t = 0; t < FEED_BEATS; t++) begin
              @(negedge clk);
              check($sformatf("a_beat%0d", t), bus_if.a_out, cur.a[t]);
              check($sformatf("b_beat%0d", t), bus_if.b_out, cur.b[t]);
              check("feed_ctrl", {bus_if.busy, bus_if.pe_reset, bus_if.done}, 3'b100);
            end
            for (int d = 0; d < DRAIN; d++) begin
              @(negedge clk);
              check("drain_feed_zero", {bus_if.a_out, bus_if.b_out}, 0);
              check("drain_ctrl", {bus_if.busy, bus_if.pe_reset, bus_if.done}, 3'b100);
            end
            @(negedge clk);
            check("done_ctrl", {bus_if.busy, bus_if.pe_reset, bus_if.done}, 3'b101);
            check("done_feed_zero", {bus_if.a_out, bus_if.b_out}, 0);
            runs_seen++;
          end
        end else begin
          check("idle_feed_zero", {bus_if.a_out, bus_if.b_out}, 0);
          check("idle_ctrl", {bus_if.busy, bus_if.done}, 2'b00);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    run_t hand;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_sel  = 1'b0;
    bus_if.wr_row  = '0;
    bus_if.wr_col  = '0;
    bus_if.wr_data = '0;
    bus_if.start   = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
      end

    #12;
    check("reset_ctrl", {bus_if.busy, bus_if.done, bus_if.pe_reset}, 3'b000);
    check("reset_feed", {bus_if.a_out, bus_if.b_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Identity x all-ones, expected beats worked out by hand.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (r == c) wr(SEL_A, r, c, 1, 1'b1);
        wr(SEL_B, r, c, 1, 1'b1);
      end
    hand.clr = cyc + 1;
    hand.a   = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h10, 8'h00, 8'h40};
    hand.b   = '{8'h01, 8'h05, 8'h15, 8'h55, 8'h54, 8'h50, 8'h40};
    start_with(hand);
    wait_runs();

    // Skew pattern: 0 for even r+c, -1 for odd.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(SEL_A, r, c, ((r + c) % 2 != 0) ? -1 : 0, 1'b1);
        wr(SEL_B, r, c, ((r + c) % 2 != 0) ? -1 : 0, 1'b1);
      end
    start_run();
    wait_runs();

    // Busy protection: write + start during DRAIN must both be ignored.
    start_run();
    repeat (8) @(negedge clk);
    bus_if.start = 1'b1;
    wr(SEL_B, 0, 0, 1, 1'b0);
    bus_if.start = 1'b0;
    wait_runs();
    start_run();
    wait_runs();

    // Write and start in the same IDLE cycle: run sees the new value.
    m_a[0][0] = DS'(-2);
    exp_q.push_back(model_run(cyc + 1));
    runs_issued++;
    bus_if.start   = 1'b1;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = SEL_A;
    bus_if.wr_row  = 2'd0;
    bus_if.wr_col  = 2'd0;
    bus_if.wr_data = DS'(-2);
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.wr_en = 1'b0;
    wait_runs();

    // Back-to-back: start held 30 cycles gives runs cleared 14 cycles apart.
    hand = model_run(cyc + 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(hand);
      runs_issued++;
      hand.clr = hand.clr + 10 + DRAIN;
    end
    bus_if.start = 1'b1;
    repeat (30) @(negedge clk);
    bus_if.start = 1'b0;
    wait_runs();

    // Reset mid-FEED at beat 3.
    mon_en = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(SEL_A, r, c, 1, 1'b1);
        wr(SEL_B, r, c, -1, 1'b1);
      end
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_a_beat3", bus_if.a_out, 8'h55);
    check("pre_reset_b_beat3", bus_if.b_out, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {bus_if.busy, bus_if.done, bus_if.pe_reset}, 3'b000);
    check("abort_feed", {bus_if.a_out, bus_if.b_out}, 0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
      end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", bus_if.busy, 0);
    mon_en = 1'b1;
    start_run();
    wait_runs();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
